// File: rtl/decode_queue.sv
// decode_queue: RV32I(M) decode stage with an input FIFO and a registered micro-op bundle.
//   Fetch side   : in_valid/in_ready handshake carrying in_instr, in_pc.
//   Execute side : out_valid/out_ready handshake carrying out_pc, out_rd/rs1/rs2, out_imm,
//                  out_alu_op, out_div_op, out_ctrl, out_mem_type.
//   Control      : clk, rst (sync, active-high), flush (drops everything in flight).
//   Status       : q_count = occupied queue entries.
//   Optional     : `define DECODE_M_EXT_EN to decode MUL*/DIV*/REM* (funct7=0x01).
module decode_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    input  logic [PC_WIDTH-1:0]            in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PC_WIDTH-1:0]            out_pc,
    output logic [4:0]                     out_rd,
    output logic [4:0]                     out_rs1,
    output logic [4:0]                     out_rs2,
    output logic [31:0]                    out_imm,
    output logic [4:0]                     out_alu_op,
    output logic [2:0]                     out_div_op,
    output logic [11:0]                    out_ctrl,
    output logic [2:0]                     out_mem_type,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]         q_instr [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                full, wr, rd;

    assign full     = q_count == CW'(QUEUE_DEPTH);
    assign in_ready = !full && !rst && !flush;
    assign wr       = in_valid && in_ready;
    assign rd       = (q_count != '0) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (wr) begin
                q_instr[wr_ptr] <= in_instr;
                q_pc[wr_ptr]    <= in_pc;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (rd)
                rd_ptr <= rd_ptr + AW'(1);
            q_count <= q_count + CW'(wr) - CW'(rd);
        end
    end

    logic [31:0] h;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign h     = q_instr[rd_ptr];
    assign opc   = h[6:0];
    assign f3    = h[14:12];
    assign f7    = h[31:25];
    assign imm_i = {{20{h[31]}}, h[31:20]};
    assign imm_s = {{20{h[31]}}, h[31:25], h[11:7]};
    assign imm_b = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
    assign imm_u = {h[31:12], 12'b0};
    assign imm_j = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};

    logic [4:0]  d_rd, d_rs1, d_rs2, d_alu;
    logic [31:0] d_imm;
    logic [2:0]  d_div, d_mem;
    logic        rw, asrc, br, jal, jalr, ld, st, lui, auipc, dv, ill;

    always_comb begin
        d_rd  = '0;
        d_rs1 = '0;
        d_rs2 = '0;
        d_alu = '0;
        d_imm = '0;
        d_div = '0;
        d_mem = '0;
        {rw, asrc, br, jal, jalr, ld, st, lui, auipc, dv, ill} = '0;
        case (opc)
            7'b0110111: begin
                d_rd  = h[11:7];
                d_imm = imm_u;
                rw    = 1'b1;
                lui   = 1'b1;
            end
            7'b0010111: begin
                d_rd  = h[11:7];
                d_imm = imm_u;
                d_alu = 5'd10;
                rw    = 1'b1;
                asrc  = 1'b1;
                auipc = 1'b1;
            end
            7'b1101111: begin
                d_rd  = h[11:7];
                d_imm = imm_j;
                rw    = 1'b1;
                jal   = 1'b1;
            end
            7'b1100111: begin
                d_rd  = h[11:7];
                d_rs1 = h[19:15];
                d_imm = imm_i;
                d_alu = 5'd10;
                rw    = 1'b1;
                asrc  = 1'b1;
                jalr  = 1'b1;
                ill   = f3 != 3'd0;
            end
            7'b1100011: begin
                d_rs1 = h[19:15];
                d_rs2 = h[24:20];
                d_imm = imm_b;
                d_mem = f3;
                br    = 1'b1;
                ill   = f3 == 3'd2 || f3 == 3'd3;
            end
            7'b0000011: begin
                d_rd  = h[11:7];
                d_rs1 = h[19:15];
                d_imm = imm_i;
                d_alu = 5'd10;
                d_mem = f3;
                rw    = 1'b1;
                asrc  = 1'b1;
                ld    = 1'b1;
                ill   = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
            end
            7'b0100011: begin
                d_rs1 = h[19:15];
                d_rs2 = h[24:20];
                d_imm = imm_s;
                d_alu = 5'd10;
                d_mem = f3;
                asrc  = 1'b1;
                st    = 1'b1;
                ill   = f3 > 3'd2;
            end
            7'b0010011: begin
                d_rd  = h[11:7];
                d_rs1 = h[19:15];
                d_imm = imm_i;
                rw    = 1'b1;
                asrc  = 1'b1;
                case (f3)
                    3'd0:    d_alu = 5'd10;
                    3'd1:    d_alu = 5'd14;
                    3'd2:    d_alu = 5'd17;
                    3'd3:    d_alu = 5'd18;
                    3'd4:    d_alu = 5'd11;
                    3'd5:    d_alu = f7[5] ? 5'd16 : 5'd15;
                    3'd6:    d_alu = 5'd12;
                    default: d_alu = 5'd13;
                endcase
                ill = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0110011: begin
                d_rd  = h[11:7];
                d_rs1 = h[19:15];
                d_rs2 = h[24:20];
                rw    = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0:    d_alu = 5'd0;
                        3'd1:    d_alu = 5'd5;
                        3'd2:    d_alu = 5'd8;
                        3'd3:    d_alu = 5'd9;
                        3'd4:    d_alu = 5'd2;
                        3'd5:    d_alu = 5'd6;
                        3'd6:    d_alu = 5'd3;
                        default: d_alu = 5'd4;
                    endcase
                end else if (f7 == 7'h20) begin
                    d_alu = f3 == 3'd5 ? 5'd7 : 5'd1;
                    ill   = f3 != 3'd0 && f3 != 3'd5;
`ifdef DECODE_M_EXT_EN
                end else if (f7 == 7'h01) begin
                    // funct3[2] separates the multiply group from the divide group
                    d_alu = f3[2] ? 5'd0 : 5'd19 + {3'b0, f3[1:0]};
                    dv    = f3[2];
                    d_div = f3[2] ? f3 : 3'd0;
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            7'b0001111: ;
            default: ill = 1'b1;
        endcase
        ill = ill || h[1:0] != 2'b11;
        // illegal words must not cause any architectural side effect downstream
        {rw, br, jal, jalr, ld, st, dv} = ill ? 7'b0 : {rw, br, jal, jalr, ld, st, dv};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_imm      <= '0;
            out_alu_op   <= '0;
            out_div_op   <= '0;
            out_ctrl     <= '0;
            out_mem_type <= '0;
        end else if (rd) begin
            out_valid    <= 1'b1;
            out_pc       <= q_pc[rd_ptr];
            out_rd       <= d_rd;
            out_rs1      <= d_rs1;
            out_rs2      <= d_rs2;
            out_imm      <= d_imm;
            out_alu_op   <= d_alu;
            out_div_op   <= d_div;
            out_ctrl     <= {1'b0, ill, dv, auipc, lui, st, ld, jalr, jal, br, asrc, rw};
            out_mem_type <= d_mem;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of queueing, flush, backpressure and decode of decode_queue.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
    logic [2:0]  out_div_op, out_mem_type, q_count;
    logic [11:0] out_ctrl;
    int          passes = 0, total = 0;

    decode_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_div_op(out_div_op),
        .out_ctrl(out_ctrl), .out_mem_type(out_mem_type), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // push one word, then hold out_ready low until the bundle shows up
    task automatic xact(input logic [31:0] instr, input logic [31:0] pc);
        int n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        check("xact_valid", out_valid, 1);
        check("xact_pc", out_pc, pc);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_q_count", q_count, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_imm", out_imm, 0);
        check("rst_pc", out_pc, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // ADDI x1,x0,5: visible after two edges
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        check("addi_lat1_valid", out_valid, 0);
        check("addi_lat1_count", q_count, 1);
        step();
        check("addi_valid", out_valid, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_rs2", out_rs2, 0);
        check("addi_imm", out_imm, 5);
        check("addi_alu", out_alu_op, 10);
        check("addi_ctrl", out_ctrl, 12'h003);
        check("addi_pc", out_pc, 32'h100);
        step();
        check("addi_consumed", out_valid, 0);

        // backpressure: 4 in the queue plus 1 in the output register
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_instr = (i << 20) | ((i + 1) << 7) | 32'h13;
            in_pc    = 32'h200 + 4 * i;
            step();
        end
        check("bp_full_ready", in_ready, 0);
        check("bp_full_count", q_count, 4);
        in_instr = 32'h00000013; in_pc = 32'h2FC;
        step();
        check("bp_no_accept", q_count, 4);
        check("bp_hold_pc", out_pc, 32'h200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_pc", out_pc, 32'h200 + 4 * i);
            check("bp_drain_rd", out_rd, i + 1);
            check("bp_drain_imm", out_imm, i);
            step();
        end
        check("bp_empty_valid", out_valid, 0);
        check("bp_empty_count", q_count, 0);

        // flush with three queued and a fresh offer in the flush cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300 + 4 * i;
            step();
        end
        check("fl_pre_count", q_count, 3);
        flush = 1'b1; in_pc = 32'h3FC;
        #1;
        check("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", q_count, 0);
        check("fl_valid", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_nothing", out_valid, 0);
        end

        // illegal words keep their slot and PC
        xact(32'h00003083, 32'h400);
        check("ill_lw_ill", out_ctrl[10], 1);
        check("ill_lw_rw", out_ctrl[0], 0);
        check("ill_lw_load", out_ctrl[5], 0);
        step();
        check("ill_hold_pc", out_pc, 32'h400);
        check("ill_hold_valid", out_valid, 1);
        consume();
        xact(32'h0000007F, 32'h404);
        check("ill_opc_ill", out_ctrl[10], 1);
        check("ill_opc_rw", out_ctrl[0], 0);
        consume();
        xact(32'h00500090, 32'h408);
        check("ill_low_ill", out_ctrl[10], 1);
        check("ill_low_rw", out_ctrl[0], 0);
        consume();

        // DIVU x3,x1,x2
        xact(32'h0220D1B3, 32'h500);
`ifdef DECODE_M_EXT_EN
        check("divu_ctrl", out_ctrl, 12'h201);
        check("divu_op", out_div_op, 5);
`else
        check("divu_ctrl", out_ctrl, 12'h400);
        check("divu_op", out_div_op, 0);
`endif
        consume();

        // BEQ x0,x0,-4
        xact(32'hFE000EE3, 32'h504);
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        check("beq_ctrl", out_ctrl, 12'h004);
        check("beq_mem", out_mem_type, 0);
        consume();

        // LUI x1,0x12345
        xact(32'h123450B7, 32'h508);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_ctrl", out_ctrl, 12'h081);
        check("lui_rd", out_rd, 1);
        consume();

        // SUB x3,x1,x2
        xact(32'h402081B3, 32'h50C);
        check("sub_alu", out_alu_op, 1);
        check("sub_regs", {out_rd, out_rs1, out_rs2}, {5'd3, 5'd1, 5'd2});
        check("sub_ctrl", out_ctrl, 12'h001);
        consume();

        // SW x2,8(x1)
        xact(32'h0020A423, 32'h510);
        check("sw_imm", out_imm, 8);
        check("sw_ctrl", out_ctrl, 12'h042);
        check("sw_mem", out_mem_type, 2);
        check("sw_regs", {out_rd, out_rs1, out_rs2}, {5'd0, 5'd1, 5'd2});
        consume();

        // FENCE is a legal no-op
        xact(32'h0FF0000F, 32'h514);
        check("fence_ctrl", out_ctrl, 12'h000);
        consume();

        // reset mid-stream clears everything
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h600;
        step();
        step();
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_rst_count", q_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pc", out_pc, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
